// File: rtl/cgra_out_capture.sv
// cgra_out_capture: captures a programmed number of valid beats from the
// CGRA 16-bit output stream into a small first-word-fall-through FIFO that a
// same-clock consumer drains through a ready/valid port. Reports state,
// beat count, completion and sticky overflow.
// Optional feature macro: CAPTURE_CHECKSUM_EN adds a 16-bit running sum of
// every word actually pushed, exposed on the checksum port.
module cgra_out_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     io_clock,
    input  logic                     io_reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         expected_len,
    input  logic [DATA_W-1:0]        io2glb_16,
    input  logic                     io2glb_1,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         captured,
    output logic                     done,
    output logic                     overflow
`ifdef CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]              checksum
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CAP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CAP_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  captured_reg;
    logic [CNT_W-1:0]  captured_next;
    logic              overflow_reg;

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [DATA_W-1:0] entry_word [DEPTH];

    logic fifo_full;
    logic pop;
    logic beat_take;
    logic push;
    logic drop;

    // A beat only counts in CAPTURE and never in a cycle where start wins.
    assign beat_take = (state_reg == ST_CAPTURE) && io2glb_1 && !start;
    assign fifo_full = (count_reg == FULL_LVL);
    assign rd_valid  = (count_reg != '0);
    assign pop       = rd_valid && rd_ready;
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign push      = beat_take && (!fifo_full || pop);
    assign drop      = beat_take && fifo_full && !pop;

    assign captured_next = (captured_reg == CAP_MAX) ? captured_reg
                                                     : captured_reg + CAP_ONE;

    // Storage: one register per entry, written only when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge io_clock) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    word_reg <= io2glb_16;
                end
            end
            assign entry_word[gi] = word_reg;
        end
    endgenerate

    // Head word falls through; gated so an empty FIFO presents zero.
    assign rd_data = rd_valid ? entry_word[rd_ptr_reg] : '0;

    // Pointers and occupancy; only reset clears the FIFO, start never does.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    // Capture control FSM with its counters and sticky flag.
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            captured_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (start) begin
            len_reg      <= expected_len;
            captured_reg <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= (expected_len == '0) ? ST_DONE : ST_CAPTURE;
        end else begin
            case (state_reg)
                ST_CAPTURE: begin
                    if (beat_take) begin
                        captured_reg <= captured_next;
                        if (drop) begin
                            overflow_reg <= 1'b1;
                        end
                        if (captured_next == len_reg) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Running sum of pushed words only; dropped beats never reach the adder.
    always_ff @(posedge io_clock) begin
        if (io_reset || start) begin
            checksum_reg <= '0;
        end else if (push) begin
            checksum_reg <= checksum_reg + 16'(io2glb_16);
        end
    end

    assign checksum = checksum_reg;
`endif

    assign state      = state_reg;
    assign captured   = captured_reg;
    assign done       = (state_reg == ST_DONE);
    assign overflow   = overflow_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_cgra_out_capture.sv
// Testbench for cgra_out_capture: directed vectors, expected read words are
// queued at stimulus time and checked by an independent read-port monitor.
module tb_cgra_out_capture;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic              io_clock = 1'b0;
    logic              io_reset;
    logic              start;
    logic [CNT_W-1:0]  expected_len;
    logic [DATA_W-1:0] io2glb_16;
    logic              io2glb_1;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        fifo_count;
    logic [1:0]        state;
    logic [CNT_W-1:0]  captured;
    logic              done;
    logic              overflow;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DATA_W-1:0] exp_q [$];

    cgra_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .io_clock     (io_clock),
        .io_reset     (io_reset),
        .start        (start),
        .expected_len (expected_len),
        .io2glb_16    (io2glb_16),
        .io2glb_1     (io2glb_1),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .fifo_count   (fifo_count),
        .state        (state),
        .captured     (captured),
        .done         (done),
        .overflow     (overflow)
`ifdef CAPTURE_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 io_clock = ~io_clock;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Read-port monitor: every accepted word must match the scoreboard head.
    initial begin
        logic [DATA_W-1:0] exp_w;
        forever begin
            @(negedge io_clock);
            if (!io_reset && rd_valid && rd_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected: got %h expected no word", rd_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (rd_data === exp_w) begin
                        pass_cnt++;
                        $display("pop  data=%h expect=%h ok", rd_data, exp_w);
                    end else begin
                        $display("FAIL pop_data: got %h expected %h", rd_data, exp_w);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("chk  %s = %0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge io_clock);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        io2glb_1  = 1'b0;
        io2glb_16 = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},    32'(state),      32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid),   32'd0);
        chk({tag, "_rd_data"},  32'(rd_data),    32'd0);
        chk({tag, "_count"},    32'(fifo_count), 32'd0);
        chk({tag, "_captured"}, 32'(captured),   32'd0);
        chk({tag, "_done"},     32'(done),       32'd0);
        chk({tag, "_overflow"}, 32'(overflow),   32'd0);
`ifdef CAPTURE_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(checksum),   32'd0);
`endif
    endtask

    task automatic arm(input int len);
        start        = 1'b1;
        expected_len = CNT_W'(len);
        io2glb_1     = 1'b0;
        cyc();
        start        = 1'b0;
    endtask

    // Drive one valid beat; optionally record it as a word that must come out.
    task automatic beat(input logic [DATA_W-1:0] d, input bit expect_push);
        io2glb_16 = d;
        io2glb_1  = 1'b1;
        if (expect_push) exp_q.push_back(d);
        cyc();
        io2glb_1  = 1'b0;
    endtask

    initial begin
        int occ;
        int sent;
        int guard;
        bit vld;

        io_reset     = 1'b1;
        rd_ready     = 1'b0;
        expected_len = '0;
        idle_inputs();
        cyc();
        cyc();
        check_reset_vals("reset");
        io_reset = 1'b0;

        // Basic capture of four beats with the consumer always ready.
        rd_ready = 1'b1;
        arm(4);
        chk("basic_state_capture", 32'(state), 32'd1);
        for (int i = 1; i <= 4; i++) beat(DATA_W'(i), 1'b1);
        chk("basic_done",     32'(done),     32'd1);
        chk("basic_captured", 32'(captured), 32'd4);
        chk("basic_overflow", 32'(overflow), 32'd0);
`ifdef CAPTURE_CHECKSUM_EN
        chk("basic_checksum", 32'(checksum), 32'h000A);
`endif
        cyc();
        chk("basic_drained", 32'(fifo_count), 32'd0);

        // Overflow: 20 beats into a 16-deep FIFO with no reads.
        rd_ready = 1'b0;
        arm(20);
        for (int i = 0; i < 20; i++) beat(DATA_W'(16'h0100 + i), i < DEPTH);
        chk("ovf_count",    32'(fifo_count), 32'd16);
        chk("ovf_overflow", 32'(overflow),   32'd1);
        chk("ovf_captured", 32'(captured),   32'd20);
        chk("ovf_done",     32'(done),       32'd1);

        // Full FIFO with a pop in the same cycle accepts the beat.
        arm(1);
        chk("full_ovf_cleared", 32'(overflow),   32'd0);
        chk("full_count_pre",   32'(fifo_count), 32'd16);
        rd_ready = 1'b1;
        beat(16'h0AAA, 1'b1);
        rd_ready = 1'b0;
        chk("full_overflow", 32'(overflow),   32'd0);
        chk("full_count",    32'(fifo_count), 32'd16);
        chk("full_done",     32'(done),       32'd1);
        rd_ready = 1'b1;
        repeat (DEPTH + 1) cyc();
        chk("full_drained", 32'(fifo_count), 32'd0);

        // Zero length goes straight to DONE; later beats are ignored.
        arm(0);
        chk("zero_state", 32'(state), 32'd2);
        chk("zero_done",  32'(done),  32'd1);
        for (int i = 0; i < 3; i++) beat(DATA_W'(16'h0E00 + i), 1'b0);
        chk("zero_captured", 32'(captured),   32'd0);
        chk("zero_count",    32'(fifo_count), 32'd0);
        chk("zero_rd_valid", 32'(rd_valid),   32'd0);

        // Restart mid-capture: the coincident beat is discarded.
        rd_ready = 1'b0;
        arm(8);
        for (int i = 1; i <= 3; i++) beat(DATA_W'(16'h0200 + i), 1'b1);
        start        = 1'b1;
        expected_len = CNT_W'(2);
        io2glb_16    = 16'h02FF;
        io2glb_1     = 1'b1;
        cyc();
        idle_inputs();
        chk("restart_captured", 32'(captured),   32'd0);
        chk("restart_count",    32'(fifo_count), 32'd3);
        chk("restart_state",    32'(state),      32'd1);
        beat(16'h0211, 1'b1);
        beat(16'h0212, 1'b1);
        chk("restart_done",     32'(done),       32'd1);
        chk("restart_captured2", 32'(captured),  32'd2);
        chk("restart_count2",   32'(fifo_count), 32'd5);
        rd_ready = 1'b1;
        repeat (5) cyc();
        chk("restart_drained", 32'(fifo_count), 32'd0);

        // Reset mid-capture, asserted together with start and a beat.
        rd_ready = 1'b0;
        arm(8);
        beat(16'h0401, 1'b0);
        beat(16'h0402, 1'b0);
        chk("midrst_count_pre", 32'(fifo_count), 32'd2);
        io_reset  = 1'b1;
        start     = 1'b1;
        io2glb_16 = 16'h0403;
        io2glb_1  = 1'b1;
        cyc();
        check_reset_vals("midrst");
        io_reset = 1'b0;
        idle_inputs();

        // Pointer wrap: 100 beats with a random consumer, paced to avoid overflow.
        occ   = 0;
        sent  = 0;
        guard = 0;
        arm(100);
        while (sent < 100 && guard < 3000) begin
            rd_ready  = ($urandom_range(0, 3) != 0);
            vld       = (occ < DEPTH) && ($urandom_range(0, 4) != 0);
            io2glb_1  = vld;
            io2glb_16 = DATA_W'(16'h3000 + sent);
            if (vld) begin
                exp_q.push_back(io2glb_16);
                sent++;
            end
            occ = occ + (vld ? 1 : 0) - ((occ > 0 && rd_ready) ? 1 : 0);
            cyc();
            guard++;
        end
        idle_inputs();
        rd_ready = 1'b0;
        chk("wrap_sent",     32'(sent),       32'd100);
        chk("wrap_captured", 32'(captured),   32'd100);
        chk("wrap_done",     32'(done),       32'd1);
        chk("wrap_overflow", 32'(overflow),   32'd0);
        chk("wrap_count",    32'(fifo_count), 32'(occ));
        rd_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        chk("wrap_drained", 32'(fifo_count), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
